regfile_issue_ctrl: RTL and testbench
=====================================

# regfile_issue_ctrl

Parametrised, pipelined successor to the combinational register-file controller. Sits between decode and the execute/memory units: maps each instruction type onto register-file read ports, tracks pending writes in a per-register scoreboard, and stalls issue on RAW/WAW hazards or a full in-flight budget. Results return on a write-back port and are committed to the register file one cycle later. Issue and dispatch both use valid/ready handshakes.

## Interface
- DATA_WIDTH, 32, register/operand width
- NUM_REGS, 32, architectural registers
- REG_AW, 5, register address width (= clog2(NUM_REGS))
- TYPE_WIDTH, 5, instruction-type width (`INSTR_*` codes from arch defines)
- MAX_INFLIGHT, 4, maximum outstanding register writes (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- issue_valid  in  1  decode offers instruction
- issue_ready  out  1  instruction accepted when valid&&ready
- issue_type  in  TYPE_WIDTH  `INSTR_*` code
- issue_src0 / issue_src1  in  REG_AW  source registers
- issue_dest  in  REG_AW  destination register
- issue_imm  in  DATA_WIDTH  immediate (LOAD_IMMEDIATE)
- read_reg_0 / read_reg_1  out  REG_AW  register-file read addresses (combinational)
- rf_rdata_0 / rf_rdata_1  in  DATA_WIDTH  register-file read data (combinational, same cycle)
- dispatch_valid  out  1  operands valid to execute
- dispatch_ready  in  1  execute accepts
- dispatch_type  out  TYPE_WIDTH; dispatch_dest  out  REG_AW
- dispatch_op0 / dispatch_op1  out  DATA_WIDTH  operands
- wb_valid  in  1; wb_dest  in  REG_AW; wb_data  in  DATA_WIDTH  result return (no backpressure)
- write_enable  out  1; write_address  out  REG_AW; write_data  out  DATA_WIDTH  register-file write port
- inflight_count  out  clog2(MAX_INFLIGHT+1)  outstanding writes
- wb_error  out  1  sticky: write-back to a non-busy register

## Operation
- Decode: ALU_OP reads src0,src1, writes dest. LOAD reads src0, writes dest. LOAD_IMMEDIATE reads none, writes dest, op1=issue_imm. STORE reads src0 (data), src1 (addr). JUMP reads src0 (cond), src1 (addr). Any other code: no reads, no write; dispatched unchanged.
- read_reg_0/1 = issue_src0/src1 when that source is used, else 0.
- Hazard: used source with busy[src]=1 (RAW); writing instruction with busy[dest]=1 (WAW); writing instruction with inflight_count==MAX_INFLIGHT.
- issue_ready = !hazard && (!dispatch_valid || dispatch_ready).
- Accept: register type, dest, op0=rf_rdata_0 (or 0 unused), op1=rf_rdata_1 / issue_imm / 0; dispatch_valid=1. Writing instruction sets busy[dest], increments count.
- Dispatch held stable while dispatch_valid && !dispatch_ready; cleared on handshake with no new accept.
- Write-back: wb_valid at cycle M registers write_enable/address/data, visible cycle M+1. At edge ending M+1: busy[write_address] cleared, count decremented (saturating at 0).
- wb_valid to a non-busy register: write still performed; wb_error set, held until reset.
- Same edge set and clear of same busy bit: set wins. Same-edge increment and decrement: count unchanged.

## Timing
- Reset: issue_ready follows hazard logic (1 after reset, scoreboard empty); dispatch_valid, dispatch_*, write_enable, write_address, write_data, inflight_count, wb_error, all busy bits = 0.
- Issue-to-dispatch latency 1 cycle; write-back-to-commit 1 cycle.
- Without bypass, dependent instruction on wb at M issues earliest at M+2.
- rst mid-operation: all state cleared immediately; pending write-backs discarded.

## Configuration
- REGFILE_BYPASS_EN defined: a source matching wb_dest (wb_valid) takes wb_data; else a source matching write_address (write_enable) takes write_data; such sources are not RAW hazards; WAW hazard waived when write_enable && write_address==dest. Wb-stage match has priority. Dependent issue earliest at M.
- Undefined: no forwarding; operands only from rf_rdata; hazards use busy bits only.

## Test plan
- Reset, ALU r3=r1+r2 with rf_rdata 5,7 -> dispatch next cycle op0=5 op1=7 dest=3, busy[3]=1, inflight_count=1.
- ALU to r3 then ALU reading r3, wb r3=0x2A at M -> no bypass: issue_ready low until M+2, write_enable at M+1; with REGFILE_BYPASS_EN: issue at M, op0=0x2A.
- MAX_INFLIGHT=4: four LOAD_IMMEDIATE to r1..r4 -> fifth writer stalls; wb r1 -> stall released cycle after commit, count 4->3->4.
- dispatch_ready low 3 cycles -> dispatch_* stable, issue_ready low, no lost/duplicated instruction.
- wb to r9 never issued -> write_enable with address 9, wb_error=1 until rst.
- Assert rst while busy[3]=1 and write pending -> all outputs 0, next write to r3 issues without stall.

Source files
------------

// File: rtl/regfile_issue_ctrl.sv
// regfile_issue_ctrl: decode-to-dispatch issue stage with a per-register write
// scoreboard, an in-flight write budget and a one-cycle write-back commit stage.
// Optional feature macro: REGFILE_BYPASS_EN (forward write-back / commit data
// into source operands and relax the matching hazards).
module regfile_issue_ctrl #(
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_REGS     = 32,
   parameter int REG_AW       = 5,
   parameter int TYPE_WIDTH   = 5,
   parameter int MAX_INFLIGHT = 4,
   parameter logic [TYPE_WIDTH-1:0] INSTR_ALU_OP         = TYPE_WIDTH'(1),
   parameter logic [TYPE_WIDTH-1:0] INSTR_LOAD           = TYPE_WIDTH'(2),
   parameter logic [TYPE_WIDTH-1:0] INSTR_LOAD_IMMEDIATE = TYPE_WIDTH'(3),
   parameter logic [TYPE_WIDTH-1:0] INSTR_STORE          = TYPE_WIDTH'(4),
   parameter logic [TYPE_WIDTH-1:0] INSTR_JUMP           = TYPE_WIDTH'(5)
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    issue_valid,
   output logic                                    issue_ready,
   input  logic [TYPE_WIDTH-1:0]                   issue_type,
   input  logic [REG_AW-1:0]                       issue_src0,
   input  logic [REG_AW-1:0]                       issue_src1,
   input  logic [REG_AW-1:0]                       issue_dest,
   input  logic [DATA_WIDTH-1:0]                   issue_imm,
   output logic [REG_AW-1:0]                       read_reg_0,
   output logic [REG_AW-1:0]                       read_reg_1,
   input  logic [DATA_WIDTH-1:0]                   rf_rdata_0,
   input  logic [DATA_WIDTH-1:0]                   rf_rdata_1,
   output logic                                    dispatch_valid,
   input  logic                                    dispatch_ready,
   output logic [TYPE_WIDTH-1:0]                   dispatch_type,
   output logic [REG_AW-1:0]                       dispatch_dest,
   output logic [DATA_WIDTH-1:0]                   dispatch_op0,
   output logic [DATA_WIDTH-1:0]                   dispatch_op1,
   input  logic                                    wb_valid,
   input  logic [REG_AW-1:0]                       wb_dest,
   input  logic [DATA_WIDTH-1:0]                   wb_data,
   output logic                                    write_enable,
   output logic [REG_AW-1:0]                       write_address,
   output logic [DATA_WIDTH-1:0]                   write_data,
   output logic [$clog2(MAX_INFLIGHT+1)-1:0]       inflight_count,
   output logic                                    wb_error
);

   localparam int CNT_W = $clog2(MAX_INFLIGHT+1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

   logic [NUM_REGS-1:0]   busy;
   logic                  use0, use1, writes;
   logic                  raw0, raw1, waw, full, hazard, accept;
   logic [DATA_WIDTH-1:0] src0_val, src1_val;

   // decode: which sources are read and whether the instruction writes dest
   always_comb begin
      use0   = 1'b0;
      use1   = 1'b0;
      writes = 1'b0;
      case (issue_type)
         INSTR_ALU_OP:         begin use0 = 1'b1; use1 = 1'b1; writes = 1'b1; end
         INSTR_LOAD:           begin use0 = 1'b1; writes = 1'b1; end
         INSTR_LOAD_IMMEDIATE: writes = 1'b1;
         INSTR_STORE:          begin use0 = 1'b1; use1 = 1'b1; end
         INSTR_JUMP:           begin use0 = 1'b1; use1 = 1'b1; end
         default: ;
      endcase
   end

   assign read_reg_0 = use0 ? issue_src0 : '0;
   assign read_reg_1 = use1 ? issue_src1 : '0;

   // operand selection and hazard detection
   always_comb begin
      full = writes && (inflight_count == MAX_CNT);
`ifdef REGFILE_BYPASS_EN
      // write-back stage is newer than the commit stage, so it is checked first
      if (wb_valid && wb_dest == issue_src0)                 src0_val = wb_data;
      else if (write_enable && write_address == issue_src0)  src0_val = write_data;
      else                                                   src0_val = rf_rdata_0;
      if (wb_valid && wb_dest == issue_src1)                 src1_val = wb_data;
      else if (write_enable && write_address == issue_src1)  src1_val = write_data;
      else                                                   src1_val = rf_rdata_1;
      raw0 = use0 && busy[issue_src0] && !(wb_valid && wb_dest == issue_src0)
                                      && !(write_enable && write_address == issue_src0);
      raw1 = use1 && busy[issue_src1] && !(wb_valid && wb_dest == issue_src1)
                                      && !(write_enable && write_address == issue_src1);
      // busy bit is cleared and re-set on the same edge; set wins
      waw  = writes && busy[issue_dest] && !(write_enable && write_address == issue_dest);
`else
      src0_val = rf_rdata_0;
      src1_val = rf_rdata_1;
      raw0 = use0 && busy[issue_src0];
      raw1 = use1 && busy[issue_src1];
      waw  = writes && busy[issue_dest];
`endif
      hazard = raw0 || raw1 || waw || full;
   end

   assign issue_ready = !hazard && (!dispatch_valid || dispatch_ready);
   assign accept      = issue_valid && issue_ready;

   // dispatch register: load on accept, hold under backpressure, drop on handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dispatch_valid <= 1'b0;
         dispatch_type  <= '0;
         dispatch_dest  <= '0;
         dispatch_op0   <= '0;
         dispatch_op1   <= '0;
      end else if (accept) begin
         dispatch_valid <= 1'b1;
         dispatch_type  <= issue_type;
         dispatch_dest  <= issue_dest;
         dispatch_op0   <= use0 ? src0_val : '0;
         dispatch_op1   <= (issue_type == INSTR_LOAD_IMMEDIATE) ? issue_imm :
                           use1 ? src1_val : '0;
      end else if (dispatch_ready) begin
         dispatch_valid <= 1'b0;
      end
   end

   // write-back capture into the commit stage; flag returns nobody was waiting for
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         write_enable  <= 1'b0;
         write_address <= '0;
         write_data    <= '0;
         wb_error      <= 1'b0;
      end else begin
         write_enable <= wb_valid;
         if (wb_valid) begin
            write_address <= wb_dest;
            write_data    <= wb_data;
            if (!busy[wb_dest]) wb_error <= 1'b1;
         end
      end
   end

   // scoreboard: clear on commit, set on accept of a writer (later NBA wins)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else begin
         if (write_enable)       busy[write_address] <= 1'b0;
         if (accept && writes)   busy[issue_dest]    <= 1'b1;
      end
   end

   // in-flight write count; simultaneous issue and commit cancel out
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_count <= '0;
      end else begin
         case ({accept && writes, write_enable})
            2'b10:   inflight_count <= inflight_count + 1'b1;
            2'b01:   if (inflight_count != '0) inflight_count <= inflight_count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_issue_ctrl.sv
// Self-checking bench for regfile_issue_ctrl: decode table, directed hazard /
// backpressure / error / reset sequences, then randomized traffic against a
// queue-based reference model. Honours REGFILE_BYPASS_EN when defined.
`timescale 1ns/1ps
module tb_regfile_issue_ctrl;
   localparam int DW = 32, NR = 32, AW = 5, TW = 5, MI = 4, CW = $clog2(MI+1);
   localparam logic [TW-1:0] T_ALU = 1, T_LD = 2, T_LI = 3, T_ST = 4, T_JMP = 5, T_OTH = 7;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0, rst;
   logic issue_valid, issue_ready;
   logic [TW-1:0] issue_type;
   logic [AW-1:0] issue_src0, issue_src1, issue_dest;
   logic [DW-1:0] issue_imm;
   logic [AW-1:0] read_reg_0, read_reg_1;
   logic [DW-1:0] rf_rdata_0, rf_rdata_1;
   logic dispatch_valid, dispatch_ready;
   logic [TW-1:0] dispatch_type;
   logic [AW-1:0] dispatch_dest;
   logic [DW-1:0] dispatch_op0, dispatch_op1;
   logic wb_valid;
   logic [AW-1:0] wb_dest;
   logic [DW-1:0] wb_data;
   logic write_enable;
   logic [AW-1:0] write_address;
   logic [DW-1:0] write_data;
   logic [CW-1:0] inflight_count;
   logic wb_error;

   logic [DW-1:0] rf [NR];
   logic rf_load;
   int tests = 0, fails = 0;

   regfile_issue_ctrl #(.DATA_WIDTH(DW), .NUM_REGS(NR), .REG_AW(AW), .TYPE_WIDTH(TW),
                        .MAX_INFLIGHT(MI)) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_type(issue_type),
      .issue_src0(issue_src0), .issue_src1(issue_src1), .issue_dest(issue_dest),
      .issue_imm(issue_imm), .read_reg_0(read_reg_0), .read_reg_1(read_reg_1),
      .rf_rdata_0(rf_rdata_0), .rf_rdata_1(rf_rdata_1),
      .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
      .dispatch_type(dispatch_type), .dispatch_dest(dispatch_dest),
      .dispatch_op0(dispatch_op0), .dispatch_op1(dispatch_op1),
      .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
      .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
      .inflight_count(inflight_count), .wb_error(wb_error));

   always #5 clk = ~clk;

   // external register file: combinational read, written by the DUT write port
   assign rf_rdata_0 = rf[read_reg_0];
   assign rf_rdata_1 = rf[read_reg_1];
   always @(posedge clk) begin
      if (rf_load) for (int i = 0; i < NR; i++) rf[i] <= 32'h100 + i;
      else if (write_enable) rf[write_address] <= write_data;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      issue_valid = 0; issue_type = '0; issue_src0 = '0; issue_src1 = '0;
      issue_dest = '0; issue_imm = '0; wb_valid = 0; wb_dest = '0; wb_data = '0;
      dispatch_ready = 1;
   endtask

   task automatic offer(input logic [TW-1:0] t, input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                        input logic [AW-1:0] d, input logic [DW-1:0] imm);
      issue_valid = 1; issue_type = t; issue_src0 = s0; issue_src1 = s1;
      issue_dest = d; issue_imm = imm;
   endtask

   task automatic wb(input logic [AW-1:0] d, input logic [DW-1:0] v);
      wb_valid = 1; wb_dest = d; wb_data = v;
   endtask

   task automatic reload_rf();
      rf_load = 1; tick(); rf_load = 0;
   endtask

   typedef struct {
      logic [TW-1:0] t;
      logic [AW-1:0] s0, s1, d;
      logic [DW-1:0] imm;
      logic [AW-1:0] rr0, rr1;
      logic [DW-1:0] op0, op1;
      logic [CW-1:0] cnt;
   } vec_t;
   vec_t vt [6];

   // reference model state for the random phase
   int pend[$];
   int await_q[$];
   logic m_dv, m_we, m_err;
   logic [TW-1:0] m_dt;
   logic [AW-1:0] m_dd, m_wa;
   logic [DW-1:0] m_d0, m_d1, m_wd;

   function automatic bit in_pend(int r);
      foreach (pend[i]) if (pend[i] == r) return 1'b1;
      return 1'b0;
   endfunction

   initial begin
      vt[0] = '{T_ALU, 5'd1,  5'd2,  5'd3,  32'h0,        5'd1,  5'd2,  32'h101, 32'h102, 3'd1};
      vt[1] = '{T_LD,  5'd4,  5'd5,  5'd6,  32'h0,        5'd4,  5'd0,  32'h104, 32'h0,   3'd1};
      vt[2] = '{T_LI,  5'd7,  5'd8,  5'd9,  32'hDEAD,     5'd0,  5'd0,  32'h0,   32'hDEAD,3'd1};
      vt[3] = '{T_ST,  5'd10, 5'd11, 5'd12, 32'h0,        5'd10, 5'd11, 32'h10A, 32'h10B, 3'd0};
      vt[4] = '{T_JMP, 5'd13, 5'd14, 5'd15, 32'h0,        5'd13, 5'd14, 32'h10D, 32'h10E, 3'd0};
      vt[5] = '{T_OTH, 5'd1,  5'd2,  5'd3,  32'h1234,     5'd0,  5'd0,  32'h0,   32'h0,   3'd0};

      // ---------------- reset
      idle(); rst = 1; rf_load = 1;
      repeat (2) @(negedge clk);
      rf_load = 0; rst = 0;
      #1;
      chk("rst_issue_ready", issue_ready, 1);
      chk("rst_dispatch_valid", dispatch_valid, 0);
      chk("rst_dispatch_op0", dispatch_op0, 0);
      chk("rst_dispatch_type", dispatch_type, 0);
      chk("rst_write_enable", write_enable, 0);
      chk("rst_write_address", write_address, 0);
      chk("rst_write_data", write_data, 0);
      chk("rst_inflight", inflight_count, 0);
      chk("rst_wb_error", wb_error, 0);

      // ---------------- decode table
      for (int i = 0; i < 6; i++) begin
         offer(vt[i].t, vt[i].s0, vt[i].s1, vt[i].d, vt[i].imm);
         #1;
         chk($sformatf("tbl%0d_rr0", i), read_reg_0, vt[i].rr0);
         chk($sformatf("tbl%0d_rr1", i), read_reg_1, vt[i].rr1);
         chk($sformatf("tbl%0d_ready", i), issue_ready, 1);
         tick(); idle(); #1;
         chk($sformatf("tbl%0d_dv", i), dispatch_valid, 1);
         chk($sformatf("tbl%0d_type", i), dispatch_type, vt[i].t);
         chk($sformatf("tbl%0d_dest", i), dispatch_dest, vt[i].d);
         chk($sformatf("tbl%0d_op0", i), dispatch_op0, vt[i].op0);
         chk($sformatf("tbl%0d_op1", i), dispatch_op1, vt[i].op1);
         chk($sformatf("tbl%0d_cnt", i), inflight_count, vt[i].cnt);
         if (vt[i].cnt != 0) wb(vt[i].d, 32'h55);
         tick(); idle(); tick(); tick(); #1;
         chk($sformatf("tbl%0d_drain", i), inflight_count, 0);
      end

      // ---------------- RAW on r3, write-back at M
      reload_rf();
      offer(T_ALU, 5'd1, 5'd2, 5'd3, 0); #1;
      chk("raw_first_ready", issue_ready, 1);
      tick();
      offer(T_ALU, 5'd3, 5'd1, 5'd4, 0); #1;
      chk("raw_busy_stall", issue_ready, 0);
      chk("raw_first_cnt", inflight_count, 1);
      tick();
      wb(5'd3, 32'h2A); #1;                      // cycle M
      if (BYP) begin
         chk("byp_ready_M", issue_ready, 1);
         tick(); idle(); #1;
         chk("byp_op0", dispatch_op0, 32'h2A);
         chk("byp_op1", dispatch_op1, 32'h101);
         chk("byp_we", write_enable, 1);
      end else begin
         chk("raw_ready_M", issue_ready, 0);
         tick(); wb_valid = 0; #1;               // M+1
         chk("raw_we", write_enable, 1);
         chk("raw_wa", write_address, 3);
         chk("raw_wd", write_data, 32'h2A);
         chk("raw_ready_M1", issue_ready, 0);
         tick(); #1;                             // M+2
         chk("raw_ready_M2", issue_ready, 1);
         tick(); idle(); #1;
         chk("raw_op0", dispatch_op0, 32'h2A);
         chk("raw_op1", dispatch_op1, 32'h101);
      end
      chk("raw_dest", dispatch_dest, 4);
      wb(5'd4, 32'h44); tick(); idle(); tick(); tick(); #1;
      chk("raw_drain", inflight_count, 0);

      // ---------------- in-flight budget
      for (int r = 1; r <= 4; r++) begin
         offer(T_LI, 0, 0, AW'(r), DW'(r)); #1;
         chk($sformatf("full_li%0d_ready", r), issue_ready, 1);
         tick();
      end
      offer(T_LI, 0, 0, 5'd5, 32'h5); #1;
      chk("full_cnt4", inflight_count, 4);
      chk("full_stall", issue_ready, 0);
      tick();
      wb(5'd1, 32'h11); #1;
      chk("full_stall_M", issue_ready, 0);
      tick(); wb_valid = 0; #1;
      chk("full_we_M1", write_enable, 1);
      chk("full_cnt_M1", inflight_count, 4);
      chk("full_stall_M1", issue_ready, 0);
      tick(); #1;
      chk("full_cnt_M2", inflight_count, 3);
      chk("full_release", issue_ready, 1);
      tick(); idle(); #1;
      chk("full_cnt_back4", inflight_count, 4);
      chk("full_dest5", dispatch_dest, 5);
      for (int r = 2; r <= 5; r++) begin wb(AW'(r), DW'(r)); tick(); end
      idle(); tick(); tick(); #1;
      chk("full_drain", inflight_count, 0);
      chk("full_no_err", wb_error, 0);

      // ---------------- dispatch backpressure
      reload_rf();
      dispatch_ready = 0;
      offer(T_ST, 5'd1, 5'd2, 5'd0, 0); #1;
      chk("bp_first_ready", issue_ready, 1);
      tick();
      offer(T_ST, 5'd5, 5'd6, 5'd0, 0);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("bp%0d_ready", k), issue_ready, 0);
         chk($sformatf("bp%0d_dv", k), dispatch_valid, 1);
         chk($sformatf("bp%0d_op0", k), dispatch_op0, 32'h101);
         chk($sformatf("bp%0d_op1", k), dispatch_op1, 32'h102);
         tick();
      end
      dispatch_ready = 1; #1;
      chk("bp_release_ready", issue_ready, 1);
      tick(); idle(); #1;
      chk("bp_second_dv", dispatch_valid, 1);
      chk("bp_second_op0", dispatch_op0, 32'h105);
      chk("bp_second_op1", dispatch_op1, 32'h106);
      tick(); #1;
      chk("bp_cleared", dispatch_valid, 0);

      // ---------------- write-back to a register nobody is waiting on
      wb(5'd9, 32'h99); #1;
      chk("err_before", wb_error, 0);
      tick(); idle(); #1;
      chk("err_we", write_enable, 1);
      chk("err_wa", write_address, 9);
      chk("err_wd", write_data, 32'h99);
      chk("err_set", wb_error, 1);
      chk("err_cnt", inflight_count, 0);
      tick(); tick(); #1;
      chk("err_sticky", wb_error, 1);
      chk("err_cnt_sat", inflight_count, 0);

      // ---------------- reset with busy[3] and a commit pending
      offer(T_LI, 0, 0, 5'd3, 32'h7); tick();
      idle(); wb(5'd3, 32'h33); tick();
      idle(); rst = 1; #1;
      chk("mid_rst_we", write_enable, 0);
      chk("mid_rst_wa", write_address, 0);
      chk("mid_rst_wd", write_data, 0);
      chk("mid_rst_dv", dispatch_valid, 0);
      chk("mid_rst_op1", dispatch_op1, 0);
      chk("mid_rst_cnt", inflight_count, 0);
      chk("mid_rst_err", wb_error, 0);
      @(negedge clk); rst = 0;
      offer(T_LI, 0, 0, 5'd3, 32'h8); #1;
      chk("post_rst_ready", issue_ready, 1);
      tick(); idle(); #1;
      chk("post_rst_dv", dispatch_valid, 1);
      chk("post_rst_cnt", inflight_count, 1);
      wb(5'd3, 32'h3); tick(); idle(); tick(); tick(); tick();

      // ---------------- randomized traffic vs reference model
      m_dv = 0; m_we = 0; m_err = 0; m_dt = '0; m_dd = '0; m_d0 = '0; m_d1 = '0;
      m_wa = '0; m_wd = '0;
      pend.delete(); await_q.delete();
      for (int cyc = 0; cyc < 600; cyc++) begin
         logic u0, u1, w, f0wb, f0wr, f1wb, f1wr, hz, e_rdy, acc;
         logic [DW-1:0] v0, v1;
         int idx;
         issue_valid = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 5))
            0: issue_type = T_ALU;  1: issue_type = T_LD;  2: issue_type = T_LI;
            3: issue_type = T_ST;   4: issue_type = T_JMP; default: issue_type = T_OTH;
         endcase
         issue_src0 = AW'($urandom_range(0, 7));
         issue_src1 = AW'($urandom_range(0, 7));
         issue_dest = AW'($urandom_range(0, 7));
         issue_imm  = $urandom;
         dispatch_ready = ($urandom_range(0, 3) != 0);
         if (await_q.size() > 0 && $urandom_range(0, 2) == 0) begin
            idx = $urandom_range(0, await_q.size() - 1);
            wb_valid = 1; wb_dest = AW'(await_q[idx]); wb_data = $urandom;
            await_q.delete(idx);
         end else begin
            wb_valid = 0; wb_dest = '0; wb_data = '0;
         end
         #1;
         u0 = (issue_type inside {T_ALU, T_LD, T_ST, T_JMP});
         u1 = (issue_type inside {T_ALU, T_ST, T_JMP});
         w  = (issue_type inside {T_ALU, T_LD, T_LI});
         f0wb = BYP && wb_valid && wb_dest == issue_src0;
         f0wr = BYP && m_we && m_wa == issue_src0;
         f1wb = BYP && wb_valid && wb_dest == issue_src1;
         f1wr = BYP && m_we && m_wa == issue_src1;
         hz = (u0 && in_pend(issue_src0) && !f0wb && !f0wr) ||
              (u1 && in_pend(issue_src1) && !f1wb && !f1wr) ||
              (w && in_pend(issue_dest) && !(BYP && m_we && m_wa == issue_dest)) ||
              (w && pend.size() == MI);
         e_rdy = !hz && (!m_dv || dispatch_ready);
         chk("rnd_ready", issue_ready, e_rdy);
         chk("rnd_rr0", read_reg_0, u0 ? issue_src0 : 5'd0);
         chk("rnd_rr1", read_reg_1, u1 ? issue_src1 : 5'd0);
         chk("rnd_dv", dispatch_valid, m_dv);
         if (m_dv) begin
            chk("rnd_dtype", dispatch_type, m_dt);
            chk("rnd_ddest", dispatch_dest, m_dd);
            chk("rnd_op0", dispatch_op0, m_d0);
            chk("rnd_op1", dispatch_op1, m_d1);
         end
         chk("rnd_we", write_enable, m_we);
         if (m_we) begin
            chk("rnd_wa", write_address, m_wa);
            chk("rnd_wd", write_data, m_wd);
         end
         chk("rnd_cnt", inflight_count, pend.size());
         chk("rnd_err", wb_error, m_err);

         // next model state, all from pre-edge values
         acc = issue_valid && e_rdy;
         v0 = f0wb ? wb_data : f0wr ? m_wd : rf[issue_src0];
         v1 = f1wb ? wb_data : f1wr ? m_wd : rf[issue_src1];
         if (wb_valid && !in_pend(wb_dest)) m_err = 1;
         if (m_we) begin
            foreach (pend[i]) if (pend[i] == m_wa) begin pend.delete(i); break; end
         end
         if (acc) begin
            m_dv = 1; m_dt = issue_type; m_dd = issue_dest;
            m_d0 = u0 ? v0 : '0;
            m_d1 = (issue_type == T_LI) ? issue_imm : (u1 ? v1 : '0);
            if (w) begin pend.push_back(issue_dest); await_q.push_back(issue_dest); end
         end else if (dispatch_ready) begin
            m_dv = 0;
         end
         m_we = wb_valid;
         if (wb_valid) begin m_wa = wb_dest; m_wd = wb_data; end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // hard stop in case anything above stalls
   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
